instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, giving the width of instruction, address and PC.
REQ-002 The block SHALL have parameter RESET_PC, default 16'h0000, giving the PC value loaded by reset.
REQ-003 The block SHALL have these ports, clock and reset first:
- clk  in  1  the single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- readM  out  1  memory read request.
- address  out  WORD_SIZE  memory read address; equals PC.
- data  in  WORD_SIZE  instruction word returned by memory.
- inputReady  in  1  memory read-data-valid strobe.
- next_PC  in  WORD_SIZE  next PC computed by the datapath stage.
- halt  in  1  halt request from control, qualified by inst_valid.
- PC  out  WORD_SIZE  address of the current instruction.
- inst  out  WORD_SIZE  latched instruction, held stable for the downstream datapath.
- inst_valid  out  1  one-cycle commit strobe; the downstream stage writes its register file and memory only in this cycle.
- num_inst  out  WORD_SIZE  count of committed instructions.
- halted  out  1  high while in HALT.

Function
REQ-004 The block SHALL implement the FSM states FETCH, WAIT, EXEC and HALT.
REQ-005 In FETCH the block SHALL drive readM=1 and address=PC, then go to WAIT unconditionally.
REQ-006 In WAIT the block SHALL hold readM=1; on inputReady=1 it SHALL latch data into inst and go to EXEC, otherwise stay in WAIT indefinitely.
REQ-007 The block SHALL ignore inputReady in FETCH, EXEC and HALT.
REQ-008 The block SHALL assert inst_valid=1 only in EXEC, for exactly one cycle per fetched instruction.
REQ-009 readM SHALL be 0 in EXEC and HALT.
REQ-010 On leaving EXEC the block SHALL load PC<=next_PC and increment num_inst by 1.
- num_inst wraps modulo 2^WORD_SIZE.
- PC and next_PC are not range-checked.
REQ-011 From EXEC the block SHALL go to HALT if halt=1, otherwise to FETCH.
REQ-012 In the EXEC cycle where halt=1, the PC update and num_inst increment SHALL still occur.
REQ-013 HALT SHALL be exited only by reset.
REQ-014 halt SHALL be sampled only in EXEC.
REQ-015 The minimum instruction period SHALL be 3 cycles: FETCH, WAIT with inputReady=1, EXEC.
REQ-016 inst SHALL change only on the WAIT->EXEC transition and hold its value otherwise, including across HALT.
REQ-017 All outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.

Reset
REQ-018 When reset=1 at a clock edge, the block SHALL load:
- state=FETCH
- PC=RESET_PC
- inst=0
- num_inst=0
REQ-019 During the reset cycle the block SHALL drive readM=0, inst_valid=0 and halted=0.
REQ-020 Reset SHALL take priority over every other event, including inputReady=1 in WAIT and inst_valid in EXEC.
REQ-021 An in-flight read abandoned by reset SHALL be dropped; the first post-reset fetch SHALL re-issue address RESET_PC.

Structure
REQ-022 The state encoding (2-bit) and the WORD_SIZE default SHALL live in the shared CPU package, alongside the opcode constants already used by control and datapath.
REQ-023 The block SHALL be a single module with no sub-modules; the PC register and the instruction register are internal to it.
REQ-024 The block SHALL sit directly upstream of datapath: its inst and PC feed datapath, and datapath's next_PC feeds back in.

Verification
REQ-025 The bench SHALL check reset and first fetch: reset for 2 cycles, then inputReady=1 in the first WAIT with data=16'h6001 -> address=0000, readM high for 2 cycles, inst=6001, inst_valid high for exactly 1 cycle, then PC=next_PC and num_inst=1.
REQ-026 The bench SHALL check memory stall: inputReady held 0 for 5 WAIT cycles -> readM stays 1, inst_valid stays 0, PC unchanged; commit occurs 1 cycle after inputReady rises.
REQ-027 The bench SHALL check back-to-back fetches: memory always ready, next_PC=PC+1 -> inst_valid every 3rd cycle; PC sequence 0,1,2,3; num_inst=4 after 12 cycles.
REQ-028 The bench SHALL check halt: halt=1 in the 3rd EXEC -> halted=1, num_inst=3, readM=0 permanently; later inputReady pulses leave inst unchanged.
REQ-029 The bench SHALL check reset mid-read: reset asserted in WAIT together with inputReady=1 and data=16'hFFFF -> inst=0, PC=RESET_PC, no inst_valid pulse, and the next fetch address is RESET_PC.
REQ-030 The bench SHALL check counter wrap: num_inst forced near FFFF by running with a reduced WORD_SIZE=4 build for 16 commits -> num_inst=0, PC continues.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Purpose : Shared CPU definitions used by control, datapath and the fetch stage.
//           Holds the default machine word size, the opcode constants and the
//           2-bit fetch-stage state encoding.
// Contents:
//   WordSizeDefault  - default width of instruction, address and PC
//   Op*              - 4-bit opcode field values (inst[WordSize-1 -: 4])
//   if_state_e       - fetch FSM state encoding
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int unsigned WordSizeDefault = 16;

  // Opcode field values decoded by control and datapath.
  localparam logic [3:0] OpAdi = 4'd4;
  localparam logic [3:0] OpOri = 4'd5;
  localparam logic [3:0] OpLhi = 4'd6;
  localparam logic [3:0] OpLwd = 4'd7;
  localparam logic [3:0] OpSwd = 4'd8;
  localparam logic [3:0] OpBne = 4'd0;
  localparam logic [3:0] OpBeq = 4'd1;
  localparam logic [3:0] OpJmp = 4'd9;
  localparam logic [3:0] OpRtype = 4'd15;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StWait  = 2'd1,
    StExec  = 2'd2,
    StHalt  = 2'd3
  } if_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Purpose : Multi-cycle fetch stage. Issues a memory read at PC, waits for the
//           read-valid strobe, latches the instruction and presents it to the
//           datapath for exactly one commit cycle, then loads the datapath's
//           next_PC. A halt seen in the commit cycle parks the block in HALT
//           until reset.
// Ports   :
//   clk         in   clock, all state changes on rising edge
//   reset       in   synchronous active-high reset
//   readM       out  memory read request (FETCH/WAIT)
//   address     out  memory read address (= PC)
//   data        in   instruction word from memory
//   inputReady  in   memory read-data-valid strobe (honoured only in WAIT)
//   next_PC     in   next PC from datapath (loaded on leaving EXEC)
//   halt        in   halt request (sampled only in EXEC)
//   PC          out  address of current instruction
//   inst        out  latched instruction
//   inst_valid  out  one-cycle commit strobe (EXEC)
//   num_inst    out  committed instruction count, wraps
//   halted      out  high while in HALT
// -----------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned          WORD_SIZE = WordSizeDefault,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 readM,
  output logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic [WORD_SIZE-1:0] next_PC,
  input  logic                 halt,
  output logic [WORD_SIZE-1:0] PC,
  output logic [WORD_SIZE-1:0] inst,
  output logic                 inst_valid,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic                 halted
);

  if_state_e            r_state;
  if_state_e            w_state_next;
  logic [WORD_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0] r_inst;
  logic [WORD_SIZE-1:0] r_num_inst;
  // High for the cycle right after a reset edge. Outputs cannot see the reset
  // input directly, so this flag keeps readM low for that cycle and holds the
  // FSM in FETCH so the first real read is still issued at RESET_PC.
  logic                 r_settle;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StFetch: if (!r_settle) w_state_next = StWait;
      StWait:  if (inputReady) w_state_next = StExec;
      StExec:  w_state_next = halt ? StHalt : StFetch;
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StFetch;
      r_pc       <= RESET_PC;
      r_inst     <= '0;
      r_num_inst <= '0;
      r_settle   <= 1'b1;
    end else begin
      r_settle <= 1'b0;
      r_state  <= w_state_next;
      if (r_state == StWait && inputReady) begin
        r_inst <= data;
      end
      // Commit happens even when halting.
      if (r_state == StExec) begin
        r_pc       <= next_PC;
        r_num_inst <= r_num_inst + 1'b1;
      end
    end
  end

  assign readM      = !r_settle && (r_state == StFetch || r_state == StWait);
  assign inst_valid = (r_state == StExec);
  assign halted     = (r_state == StHalt);
  assign address    = r_pc;
  assign PC         = r_pc;
  assign inst       = r_inst;
  assign num_inst   = r_num_inst;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Drives a 16-bit and a 4-bit instance of instruction_fetch with identical
// control stimulus and compares both against a cycle-level behavioural model.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        inputReady = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] data = '0;
  logic [15:0] next_PC = '0;

  logic        readm16, iv16, halted16;
  logic [15:0] addr16, pc16, inst16, num16;
  logic        readm4, iv4, halted4;
  logic [3:0]  addr4, pc4, inst4, num4;

  instruction_fetch #(.WORD_SIZE(16), .RESET_PC(16'h0000)) u_dut16 (
    .clk        (clk),
    .reset      (reset),
    .readM      (readm16),
    .address    (addr16),
    .data       (data),
    .inputReady (inputReady),
    .next_PC    (next_PC),
    .halt       (halt),
    .PC         (pc16),
    .inst       (inst16),
    .inst_valid (iv16),
    .num_inst   (num16),
    .halted     (halted16)
  );

  instruction_fetch #(.WORD_SIZE(4), .RESET_PC(4'h0)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .readM      (readm4),
    .address    (addr4),
    .data       (data[3:0]),
    .inputReady (inputReady),
    .next_PC    (next_PC[3:0]),
    .halt       (halt),
    .PC         (pc4),
    .inst       (inst4),
    .inst_valid (iv4),
    .num_inst   (num4),
    .halted     (halted4)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase 0=fetch 1=wait 2=exec 3=halt; settle = first cycle after reset.
  int          m_phase  = 0;
  bit          m_settle = 1'b1;
  logic [15:0] m_pc     = '0;
  logic [15:0] m_inst   = '0;
  logic [15:0] m_num    = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_phase = 0; m_settle = 1'b1; m_pc = '0; m_inst = '0; m_num = '0;
    end else if (m_settle) begin
      m_settle = 1'b0;
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: if (inputReady) begin m_inst = data; m_phase = 2; end
        2: begin m_pc = next_PC; m_num = m_num + 16'd1; m_phase = halt ? 3 : 0; end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    bit e_rd, e_iv, e_h;
    e_rd = !m_settle && (m_phase < 2);
    e_iv = (m_phase == 2);
    e_h  = (m_phase == 3);
    check("readM16", {31'd0, readm16}, {31'd0, e_rd});
    check("inst_valid16", {31'd0, iv16}, {31'd0, e_iv});
    check("halted16", {31'd0, halted16}, {31'd0, e_h});
    check("address16", {16'd0, addr16}, {16'd0, m_pc});
    check("PC16", {16'd0, pc16}, {16'd0, m_pc});
    check("inst16", {16'd0, inst16}, {16'd0, m_inst});
    check("num_inst16", {16'd0, num16}, {16'd0, m_num});
    check("readM4", {31'd0, readm4}, {31'd0, e_rd});
    check("inst_valid4", {31'd0, iv4}, {31'd0, e_iv});
    check("halted4", {31'd0, halted4}, {31'd0, e_h});
    check("PC4", {28'd0, pc4}, {28'd0, m_pc[3:0]});
    check("address4", {28'd0, addr4}, {28'd0, m_pc[3:0]});
    check("inst4", {28'd0, inst4}, {28'd0, m_inst[3:0]});
    check("num_inst4", {28'd0, num4}, {28'd0, m_num[3:0]});
  endtask

  task automatic cycle(input bit r, input bit rdy, input logic [15:0] d,
                       input logic [15:0] npc, input bit h);
    reset = r; inputReady = rdy; data = d; next_PC = npc; halt = h;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int          pulses;
    int          commits;
    logic [15:0] saved_inst;

    // Reset and first fetch; inputReady held high to show FETCH ignores it.
    cycle(1, 0, 16'h0, 16'h0, 0);
    cycle(1, 0, 16'h0, 16'h0, 0);
    check("rst_inst", {16'd0, inst16}, 32'h0);
    check("rst_readM", {31'd0, readm16}, 32'h0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 16'h6001, 16'h0010, 0);
      if (i == 0) check("first_addr", {16'd0, addr16}, 32'h0000);
      if (iv16) pulses++;
    end
    check("first_inst", {16'd0, inst16}, 32'h6001);
    check("first_pulses", pulses, 1);
    check("first_pc", {16'd0, pc16}, 32'h0010);
    check("first_num", {16'd0, num16}, 32'd1);

    // Memory stall of 5 WAIT cycles.
    cycle(0, 0, 16'h0, 16'h0, 0);
    repeat (5) cycle(0, 0, 16'h0, 16'h0, 0);
    check("stall_pc", {16'd0, pc16}, 32'h0010);
    cycle(0, 1, 16'hA5A5, 16'h0, 0);
    check("stall_commit", {31'd0, iv16}, 32'd1);
    cycle(0, 0, 16'h0, 16'h0020, 0);
    check("stall_pc_next", {16'd0, pc16}, 32'h0020);

    // Back-to-back fetches, next_PC = PC + 1.
    cycle(1, 0, 16'h0, 16'h0, 0);
    cycle(0, 0, 16'h0, 16'h0, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, 16'h1000 + 16'(i), m_pc + 16'd1, 0);
      if (iv16) begin
        check("b2b_pc", {16'd0, pc16}, pulses);
        check("b2b_period", i % 3, 1);
        pulses++;
      end
    end
    check("b2b_num", {16'd0, num16}, 32'd4);

    // Halt at the third EXEC; halt toggles randomly elsewhere and must be ignored.
    cycle(1, 0, 16'h0, 16'h0, 0);
    cycle(0, 0, 16'h0, 16'h0, 0);
    for (int i = 0; i < 30 && m_phase != 3; i++) begin
      cycle(0, 1, 16'h2000 + 16'(i), m_pc + 16'd2,
            (m_phase == 2) ? (m_num == 16'd2) : 1'($urandom_range(0, 1)));
    end
    check("halt_reached", {31'd0, halted16}, 32'd1);
    check("halt_num", {16'd0, num16}, 32'd3);
    saved_inst = m_inst;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    check("halt_inst_hold", {16'd0, inst16}, {16'd0, saved_inst});
    check("halt_readM", {31'd0, readm16}, 32'd0);

    // Reset while in WAIT with a valid read returning.
    cycle(1, 0, 16'h0, 16'h0, 0);
    cycle(0, 0, 16'h0, 16'h0, 0);
    cycle(0, 0, 16'h0, 16'h0, 0);
    cycle(0, 0, 16'h0, 16'h0, 0);
    cycle(1, 1, 16'hFFFF, 16'h1234, 0);
    check("midrd_inst", {16'd0, inst16}, 32'h0);
    check("midrd_iv", {31'd0, iv16}, 32'h0);
    cycle(0, 1, 16'hFFFF, 16'h1234, 0);
    cycle(0, 0, 16'h0, 16'h0, 0);
    check("midrd_addr", {16'd0, addr16}, 32'h0);

    // Counter wrap in the 4-bit build: 16 commits, next_PC = PC + 3.
    cycle(1, 0, 16'h0, 16'h0, 0);
    cycle(0, 0, 16'h0, 16'h0, 0);
    for (int i = 0; i < 48; i++) cycle(0, 1, 16'($urandom), m_pc + 16'd3, 0);
    check("wrap_num4", {28'd0, num4}, 32'd0);
    check("wrap_num16", {16'd0, num16}, 32'd16);
    check("wrap_pc16", {16'd0, pc16}, 32'h0030);

    // Randomized traffic.
    commits = 0;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 16'($urandom),
            16'($urandom), 1'($urandom_range(0, 7) == 0));
      if (iv16) commits++;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
